// File: rtl/seq_shift_add_mult.sv
// ---------------------------------------------------------------------------
// seq_shift_add_mult
//
// Iterative shift-and-add multiplier controller. It multiplies one operand
// pair per in_valid/in_ready handshake. The result is 2*WIDTH bits wide and
// appears after WIDTH iterations.
//
// The adder is not inside this block. It is a WIDTH-bit combinational adder
// instantiated at the parent level. On every cycle this block drives the
// adder operands from its registers and takes back the sum and carry-out.
//
// Optional feature (build macro SEQ_MULT_SIGNED_EN):
//   Defining the macro adds the input signed_op. When signed_op=1 the pair
//   is multiplied as two's complement numbers. Each shift feeds in a
//   sign-extension bit. On the last iteration the multiplicand weight is
//   subtracted instead of added. Without the macro every operation is
//   unsigned.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset
//   in_valid   operand pair valid          in_ready   block can accept a pair
//   mcand      multiplicand (WIDTH)        mplier     multiplier (WIDTH)
//   out_valid  product valid               out_ready  downstream accepts
//   product    2*WIDTH result, held stable while out_valid=1
//   add_a      adder operand A (accumulator high half)
//   add_b      adder operand B (multiplicand, its inverse, or zero)
//   add_cin    adder carry-in
//   add_sum    adder sum                   add_cout   adder carry-out
//   signed_op  (SEQ_MULT_SIGNED_EN only) signed operation, captured at accept
// ---------------------------------------------------------------------------
module seq_shift_add_mult #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
`ifdef SEQ_MULT_SIGNED_EN
  ,
  input  logic               signed_op
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_r;
  logic [WIDTH-1:0]   acc_hi_r;
  logic [WIDTH-1:0]   acc_lo_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [CNT_W-1:0]   cnt_r;
`ifdef SEQ_MULT_SIGNED_EN
  logic               signed_r;
`endif

  logic               last_iter_s;
  logic               shift_in_s;
  logic [WIDTH-1:0]   next_hi_s;
  logic [WIDTH-1:0]   next_lo_s;

  // Adder drive and next accumulator value, combinational from registers only
  always_comb begin
    last_iter_s = (state_r == CALC) && (cnt_r == LAST_CNT);
    add_a       = acc_hi_r;
    add_cin     = 1'b0;
    if (acc_lo_r[0]) begin
      add_b = mcand_r;
    end else begin
      add_b = {WIDTH{1'b0}};
    end
    // The unsigned product keeps the adder carry-out as the bit shifted into the top.
    shift_in_s = add_cout;
`ifdef SEQ_MULT_SIGNED_EN
    if (signed_r) begin
      // The multiplier MSB has negative weight, so the final partial product is subtracted.
      if (last_iter_s && acc_lo_r[0]) begin
        add_b   = ~mcand_r;
        add_cin = 1'b1;
      end else begin
        add_cin = 1'b0;
      end
      // This bit is the true sign of the signed sum, with one bit of extension.
      shift_in_s = add_a[WIDTH-1] ^ add_b[WIDTH-1] ^ add_cout;
    end else begin
      shift_in_s = add_cout;
    end
`endif
    next_hi_s = {shift_in_s, add_sum[WIDTH-1:1]};
    next_lo_s = {add_sum[0], acc_lo_r[WIDTH-1:1]};
  end

  // Control FSM, datapath registers and registered handshake/product outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= {(2*WIDTH){1'b0}};
      acc_hi_r  <= {WIDTH{1'b0}};
      acc_lo_r  <= {WIDTH{1'b0}};
      mcand_r   <= {WIDTH{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
`ifdef SEQ_MULT_SIGNED_EN
      signed_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            mcand_r  <= mcand;
            acc_lo_r <= mplier;
            acc_hi_r <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
`ifdef SEQ_MULT_SIGNED_EN
            signed_r <= signed_op;
`endif
            in_ready <= 1'b0;
            state_r  <= CALC;
          end else begin
            state_r  <= IDLE;
          end
        end
        CALC: begin
          acc_hi_r <= next_hi_s;
          acc_lo_r <= next_lo_s;
          cnt_r    <= cnt_r + CNT_ONE;
          if (last_iter_s) begin
            // The product register is loaded once here and then holds during DONE.
            product   <= {next_hi_s, next_lo_s};
            out_valid <= 1'b1;
            state_r   <= DONE;
          end else begin
            state_r   <= CALC;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            state_r   <= DONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_shift_add_mult.md
Name: seq_shift_add_mult

Overview:
- Iterative shift-and-add unsigned multiplier controller in the mult datapath.
- Sits directly upstream of the 16-bit carry-lookahead adder. Each cycle it drives that adder's operand and carry-in ports, and it consumes the adder's sum and carry-out.
- Accepts one operand pair per valid/ready handshake and returns a 2*WIDTH product after WIDTH iterations.
- The adder is external: instantiated alongside at the parent level, so a single adder is shared per multiplier.

Parameters:
- WIDTH, 16, operand width; must match the attached adder width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- mcand  in  WIDTH  multiplicand.
- mplier  in  WIDTH  multiplier.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts product.
- product  out  2*WIDTH  result.
- add_a  out  WIDTH  adder operand A (accumulator high half).
- add_b  out  WIDTH  adder operand B (multiplicand or zero).
- add_cin  out  1  adder carry-in.
- add_sum  in  WIDTH  adder sum.
- add_cout  in  1  adder carry-out.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; in_ready=1; out_valid=0; product=0.
  - acc_hi, acc_lo, mcand_r, cnt all cleared.
  - Applies mid-operation: any in-flight result is discarded, with no output pulse.
- States:
  - IDLE: in_ready=1. When in_valid=1, on the edge: mcand_r<=mcand, acc_lo<=mplier, acc_hi<=0, cnt<=0, go to CALC.
  - CALC: in_ready=0. Each edge performs one iteration:
    - acc_hi <= {add_cout, add_sum[WIDTH-1:1]}
    - acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]}
    - cnt <= cnt+1
    - When cnt==WIDTH-1, go to DONE.
  - DONE: out_valid=1; product={acc_hi,acc_lo}, held stable. When out_ready=1, on the edge go to IDLE.
- Adder drive, combinational from registers:
  - add_a=acc_hi.
  - add_b = acc_lo[0] ? mcand_r : 0.
  - add_cin=0 (unsigned build).
  - Outside CALC, add_a/add_b are don't-care but must not be X; they are driven from the registers.
- Adder path: the adder is purely combinational and must settle within one clk period. There is no pipelining on the adder path.
- Latency: accept edge E0; out_valid=1 after edge E0+WIDTH (16 cycles at default). Throughput is one product per WIDTH+2 cycles minimum.
- in_ready and in_valid are ignored outside IDLE. Operands may change freely after the accept edge.
- out_valid never deasserts before out_ready=1. product is stable while out_valid=1.
- out_ready is ignored outside DONE.
- No combinational path from in_valid or out_ready to any output except through state.
- Boundary cases:
  - mplier=0: full WIDTH iterations still run; product=0.
  - mcand=0: product=0.
  - Max operands: carry-out is captured every iteration, so there is no overflow loss.

Optional Feature:
- Macro: SEQ_MULT_SIGNED_EN. When defined, it adds input port signed_op (1 bit), captured with the operands at the accept edge.
- Signed mode (signed_op=1), two's complement:
  - Iterations 0..WIDTH-2 shift in add_a[WIDTH-1]^add_b[WIDTH-1]^add_cout instead of add_cout (sign extension).
  - Final iteration (cnt==WIDTH-1), when acc_lo[0]=1: add_b=~mcand_r, add_cin=1 (subtract). It shifts in the same sign formula.
- Unsigned mode (signed_op=0): behaviour is identical to the unsigned build.
- Without the macro: the port is absent and all operations are unsigned.

Test Plan:
- Basic product: mcand=3, mplier=5, out_ready=1 → out_valid 16 cycles after accept; product=0x0000000F; in_ready=0 during CALC.
- Max operands: mcand=0xFFFF, mplier=0xFFFF → product=0xFFFE0001. Every carry-out is captured.
- Zero operands and back-pressure:
  - mcand=0x1234, mplier=0 → product=0. Hold out_ready=0 for 10 cycles: out_valid and product remain stable.
  - Then out_ready=1 → IDLE next edge, in_ready=1.
- Reset mid-CALC: rst_n=0 at iteration 7 → next edge state IDLE, out_valid=0, product=0. A new pair 7*9 → product=0x0000003F.
- Back-to-back: in_valid held high with 0x00FF*0x0100, then 0xABCD*0x0002 → products 0x0000FF00 and 0x0001579A, in order, with no lost or duplicated result.
- Signed build (SEQ_MULT_SIGNED_EN):
  - signed_op=1, mcand=0xFFFD (-3), mplier=5 → 0xFFFFFFF1.
  - mcand=0x8000, mplier=0x8000 → 0x40000000.
  - signed_op=0 with the same 0xFFFD*5 → 0x0004FFF1.
